// File: rtl/rv_pkg.sv
// Shared fetch-path types and constants.
package rv_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        STALL = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Instruction buffer: registered head, flush clears occupancy; push+pop legal when full.
// Latency: push visible at data_o one cycle later; pop refused when empty, push refused when full without pop.
module rv_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almost_full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o       = (cnt_q == '0);
    assign full_o        = (cnt_q == CNT_FULL);
    assign almost_full_o = (cnt_q == CNT_LAST);
    assign data_o        = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch: one outstanding imem request, responses buffered in rv_fetch_fifo, redirect flushes.
// Optional RV_FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault_o and parks the FSM in IDLE.
module rv_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
`ifdef RV_FETCH_ALIGN_CHECK_EN
    output logic        fetch_fault_o,
`endif
    input  logic        branch_i,
    input  logic [31:0] branch_pc_i,
    input  logic [31:0] branch_offset_i
);

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q, pend_addr_q;
    logic         req_q, discard_q, fault_q;

    logic [31:0]  target_raw, target;
    logic         redirect_fault;
    logic         fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_almost_full;
    logic         fill_on_push;
    logic [63:0]  fifo_head;

    assign target_raw = branch_pc_i + branch_offset_i;

`ifdef RV_FETCH_ALIGN_CHECK_EN
    assign target         = target_raw;
    assign redirect_fault = |target_raw[1:0];
    assign fetch_fault_o  = fault_q;
`else
    assign target         = word_align(target_raw);
    assign redirect_fault = 1'b0;
`endif

    // A redirect always kills whatever response is in flight, so never push during one.
    assign fifo_push    = (state_q == WAIT) && imem_rvalid_i && !discard_q && !branch_i;
    assign fifo_pop     = instr_valid_o && instr_ready_i;
    assign fill_on_push = fifo_almost_full && !fifo_pop;

    rv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (branch_i),
        .push_i        (fifo_push),
        .data_i        ({pend_addr_q, imem_rdata_i}),
        .pop_i         (fifo_pop),
        .data_o        (fifo_head),
        .empty_o       (fifo_empty),
        .full_o        (fifo_full),
        .almost_full_o (fifo_almost_full)
    );

    assign imem_req_o    = req_q;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = !fifo_empty;
    assign pc_o          = fifo_head[63:32];
    assign instr_o       = fifo_head[31:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            fetch_pc_q  <= BOOT_ADDR;
            pend_addr_q <= '0;
            discard_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else if (branch_i) begin
            fetch_pc_q <= target;
            if (redirect_fault) begin
                fault_q   <= 1'b1;
                state_q   <= IDLE;
                req_q     <= 1'b0;
                discard_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= fault_q ? IDLE : REQ;
                        req_q   <= !fault_q;
                    end
                    REQ: begin
                        if (imem_gnt_i) begin
                            state_q   <= WAIT;
                            req_q     <= 1'b0;
                            discard_q <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid_i) begin
                            state_q   <= REQ;
                            req_q     <= 1'b1;
                            discard_q <= 1'b0;
                        end else begin
                            discard_q <= 1'b1;
                        end
                    end
                    STALL: begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= fault_q ? IDLE : REQ;
                    req_q   <= !fault_q;
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        state_q     <= WAIT;
                        req_q       <= 1'b0;
                        pend_addr_q <= fetch_pc_q;
                        fetch_pc_q  <= fetch_pc_q + INSTR_BYTES;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        discard_q <= 1'b0;
                        if (discard_q || !fill_on_push) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!fifo_full || fifo_pop) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
